vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- COLOR_BITS, 3, bits per colour channel
- CNT_BITS, 10, width of the column and row count inputs
- TOTAL_COLS / TOTAL_ROWS, 800 / 525, full line / frame length
- ACTIVE_COLS / ACTIVE_ROWS, 640 / 480, visible region
- FRONT_PORCH_HORZ / BACK_PORCH_HORZ, 18 / 50, horizontal porches
- FRONT_PORCH_VERT / BACK_PORCH_VERT, 10 / 33, vertical porches
- HSYNC_POL / VSYNC_POL, 0 / 0, sync active level (0 = active-low pulse)
- DELAY, 2, pipeline stages from count input to all outputs (legal range 1..8)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_Clk, in, 1, single clock; all logic on its rising edge
- i_Rst_L, in, 1, reset, asynchronous assert, active-low
- i_Pix_En, in, 1, pixel-advance enable; pipeline shifts only when 1
- i_Col_Count / i_Row_Count, in, CNT_BITS each, current pixel position
- i_Red_Video / i_Grn_Video / i_Blu_Video, in, COLOR_BITS each, pixel colour
- o_HSync / o_VSync, out, 1 each, sync outputs at the programmed polarity
- o_Active, out, 1, data-enable: 1 inside the visible region
- o_Line_Start, out, 1, 1 for the pixel with col = 0
- o_Frame_Start, out, 1, 1 for the pixel with col = 0 and row = 0
- o_Range_Err, out, 1, sticky: a count at or above TOTAL was received
- o_Red_Video / o_Grn_Video / o_Blu_Video, out, COLOR_BITS each, aligned, blanked colour

Function
REQ-003 The horizontal pulse region SHALL be ACTIVE_COLS+FRONT_PORCH_HORZ <= col <= TOTAL_COLS-BACK_PORCH_HORZ-1 (658..749 at defaults); the vertical region SHALL use the same form with row (490..491).
REQ-004 Inside its pulse region each sync SHALL drive its POL level; outside, it SHALL drive the inverse.
REQ-005 Visible SHALL mean col < ACTIVE_COLS and row < ACTIVE_ROWS; o_Active SHALL equal visible.
REQ-006 Colour outputs SHALL pass the input when visible and SHALL be 0 otherwise.
REQ-007 Stage 1 SHALL register the decoded flags and gated colour; stages 2..DELAY SHALL form a shift register.
REQ-008 Every output except o_Range_Err SHALL reflect the input presented DELAY enabled cycles earlier; all outputs SHALL stay mutually aligned.
REQ-009 When i_Pix_En = 0, all stages SHALL hold and outputs SHALL not change; o_Line_Start and o_Frame_Start SHALL therefore persist while the pipeline is stalled.
REQ-010 A col >= TOTAL_COLS or row >= TOTAL_ROWS SHALL be treated as blanking: sync inactive, o_Active 0, colour 0, no start pulses.
REQ-011 Such an input with i_Pix_En = 1 SHALL set o_Range_Err on the next clock; only reset SHALL clear it.
REQ-012 Counts SHALL be compared unsigned at CNT_BITS width; the wrap from (799,524) to (0,0) SHALL need no special handling beyond REQ-003 to REQ-010.
REQ-013 An input with col = 0 and row = 0 SHALL raise both o_Line_Start and o_Frame_Start for that pixel.

Reset
REQ-014 While i_Rst_L = 0, every pipeline stage SHALL be cleared to its inactive value: sync at ~POL, o_Active 0, start pulses 0, colour 0; o_Range_Err SHALL be 0.
REQ-015 A reset asserted mid-frame SHALL flush the pipeline immediately, without waiting for a clock edge.
REQ-016 After reset release, outputs SHALL keep the inactive values until DELAY enabled cycles have passed, then track the input per REQ-008.

Verification
REQ-017 A bench SHALL cover these scenarios:
- Defaults, one full frame with i_Pix_En = 1: o_HSync low for 92 pixels per line starting at col 658 and 2 clocks late; o_VSync low during rows 490..491; o_Active count = 307200.
- HSYNC_POL = 1, DELAY = 5: o_HSync high only for col 658..749, 5 cycles after the input; colour, o_Active and syncs stay aligned.
- Input (639,0) colour 7/7/7, then (640,0) colour 7/7/7: outputs 7/7/7 then 0/0/0, 2 cycles later.
- i_Pix_En toggled 1,0,0,1 around (0,0): o_Frame_Start held across the stall; exactly one frame-start pixel emitted.
- Col = 900 with i_Pix_En = 1: o_Range_Err goes 1 next clock, sync inactive, colour 0; o_Range_Err stays 1 until i_Rst_L = 0.
- i_Rst_L pulsed low at (300,200): outputs go inactive immediately; after release, first valid pixel emerges DELAY enabled cycles later.

Source files
------------

// File: rtl/vga_sync_if.sv
// Pixel-stream bundle between a raster counter and the VGA sync generator:
// position, colour and pixel enable in, aligned sync/data-enable/colour out.
interface vga_sync_if #(
  parameter int COLOR_BITS = 3,
  parameter int CNT_BITS   = 10
);
  logic                  i_Pix_En;
  logic [CNT_BITS-1:0]   i_Col_Count;
  logic [CNT_BITS-1:0]   i_Row_Count;
  logic [COLOR_BITS-1:0] i_Red_Video;
  logic [COLOR_BITS-1:0] i_Grn_Video;
  logic [COLOR_BITS-1:0] i_Blu_Video;
  logic                  o_HSync;
  logic                  o_VSync;
  logic                  o_Active;
  logic                  o_Line_Start;
  logic                  o_Frame_Start;
  logic                  o_Range_Err;
  logic [COLOR_BITS-1:0] o_Red_Video;
  logic [COLOR_BITS-1:0] o_Grn_Video;
  logic [COLOR_BITS-1:0] o_Blu_Video;

  modport master (
    output i_Pix_En, i_Col_Count, i_Row_Count, i_Red_Video, i_Grn_Video, i_Blu_Video,
    input  o_HSync, o_VSync, o_Active, o_Line_Start, o_Frame_Start, o_Range_Err,
           o_Red_Video, o_Grn_Video, o_Blu_Video
  );

  modport slave (
    input  i_Pix_En, i_Col_Count, i_Row_Count, i_Red_Video, i_Grn_Video, i_Blu_Video,
    output o_HSync, o_VSync, o_Active, o_Line_Start, o_Frame_Start, o_Range_Err,
           o_Red_Video, o_Grn_Video, o_Blu_Video
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA sync generator: decodes column/row counts into sync, data-enable, start
// pulses and blanked colour, delayed through a DELAY-stage enable-gated pipeline.
module vga_sync_gen #(
  parameter int   COLOR_BITS       = 3,
  parameter int   CNT_BITS         = 10,
  parameter int   TOTAL_COLS       = 800,
  parameter int   TOTAL_ROWS       = 525,
  parameter int   ACTIVE_COLS      = 640,
  parameter int   ACTIVE_ROWS      = 480,
  parameter int   FRONT_PORCH_HORZ = 18,
  parameter int   BACK_PORCH_HORZ  = 50,
  parameter int   FRONT_PORCH_VERT = 10,
  parameter int   BACK_PORCH_VERT  = 33,
  parameter logic HSYNC_POL        = 1'b0,
  parameter logic VSYNC_POL        = 1'b0,
  parameter int   DELAY            = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  vga_sync_if.slave  vif
);

  typedef struct packed {
    logic                  hsync;
    logic                  vsync;
    logic                  active;
    logic                  line_start;
    logic                  frame_start;
    logic [COLOR_BITS-1:0] red;
    logic [COLOR_BITS-1:0] grn;
    logic [COLOR_BITS-1:0] blu;
  } stage_t;

  // Blanking value: syncs at their inactive level, everything else zero.
  localparam stage_t IDLE = stage_t'({~HSYNC_POL, ~VSYNC_POL, 3'b000, {(3*COLOR_BITS){1'b0}}});

  localparam logic [31:0] COLS_W  = 32'(TOTAL_COLS);
  localparam logic [31:0] ROWS_W  = 32'(TOTAL_ROWS);
  localparam logic [31:0] ACOLS_W = 32'(ACTIVE_COLS);
  localparam logic [31:0] AROWS_W = 32'(ACTIVE_ROWS);
  localparam logic [31:0] H_BEG_W = 32'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [31:0] H_END_W = 32'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
  localparam logic [31:0] V_BEG_W = 32'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [31:0] V_END_W = 32'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

  logic [31:0] col_s;
  logic [31:0] row_s;
  logic        in_range_s;
  logic        visible_s;
  logic        h_pulse_s;
  logic        v_pulse_s;
  stage_t      decode_s;
  stage_t      stage_r [DELAY];
  logic        range_err_r;

  // Decode the current position into the stage-1 record; out-of-range counts blank.
  always_comb begin
    col_s      = 32'(vif.i_Col_Count);
    row_s      = 32'(vif.i_Row_Count);
    in_range_s = (col_s < COLS_W) && (row_s < ROWS_W);
    visible_s  = in_range_s && (col_s < ACOLS_W) && (row_s < AROWS_W);
    h_pulse_s  = in_range_s && (col_s >= H_BEG_W) && (col_s <= H_END_W);
    v_pulse_s  = in_range_s && (row_s >= V_BEG_W) && (row_s <= V_END_W);

    decode_s             = IDLE;
    decode_s.hsync       = h_pulse_s ? HSYNC_POL : ~HSYNC_POL;
    decode_s.vsync       = v_pulse_s ? VSYNC_POL : ~VSYNC_POL;
    decode_s.active      = visible_s;
    decode_s.line_start  = in_range_s && (col_s == 32'd0);
    decode_s.frame_start = in_range_s && (col_s == 32'd0) && (row_s == 32'd0);
    if (visible_s) begin
      decode_s.red = vif.i_Red_Video;
      decode_s.grn = vif.i_Grn_Video;
      decode_s.blu = vif.i_Blu_Video;
    end else begin
      decode_s.red = '0;
      decode_s.grn = '0;
      decode_s.blu = '0;
    end
  end

  // Enable-gated pipeline: stage 0 captures the decode, later stages shift.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < DELAY; i++) begin
        stage_r[i] <= IDLE;
      end
    end else if (vif.i_Pix_En) begin
      stage_r[0] <= decode_s;
      for (int i = 1; i < DELAY; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Sticky flag for any enabled count outside the programmed frame.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      range_err_r <= 1'b0;
    end else if (vif.i_Pix_En && !in_range_s) begin
      range_err_r <= 1'b1;
    end
  end

  assign vif.o_HSync       = stage_r[DELAY-1].hsync;
  assign vif.o_VSync       = stage_r[DELAY-1].vsync;
  assign vif.o_Active      = stage_r[DELAY-1].active;
  assign vif.o_Line_Start  = stage_r[DELAY-1].line_start;
  assign vif.o_Frame_Start = stage_r[DELAY-1].frame_start;
  assign vif.o_Red_Video   = stage_r[DELAY-1].red;
  assign vif.o_Grn_Video   = stage_r[DELAY-1].grn;
  assign vif.o_Blu_Video   = stage_r[DELAY-1].blu;
  assign vif.o_Range_Err   = range_err_r;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default instance (DELAY 2) and HSYNC_POL=1/DELAY 5
// instance, driven identically and checked against a pixel-history model.
module tb_vga_sync_gen;
  localparam int DA = 2;
  localparam int DB = 5;
  localparam int TC = 800, TR = 525, AC = 640, AR = 480;
  localparam int HS0 = 658, HS1 = 749, VS0 = 490, VS1 = 491;

  typedef struct {
    int         col;
    int         row;
    logic [2:0] r, g, b;
  } pix_t;

  typedef struct packed {
    logic       hs, vs, act, ls, fs;
    logic [2:0] r, g, b;
  } out_t;

  typedef struct {
    int         col;
    int         row;
    logic [2:0] r, g, b;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_sync_if #(.COLOR_BITS(3), .CNT_BITS(10)) ifa ();
  vga_sync_if #(.COLOR_BITS(3), .CNT_BITS(10)) ifb ();

  vga_sync_gen #(.DELAY(DA)) dut_a (.i_Clk(clk), .i_Rst_L(rst_n), .vif(ifa));
  vga_sync_gen #(.HSYNC_POL(1'b1), .DELAY(DB)) dut_b (.i_Clk(clk), .i_Rst_L(rst_n), .vif(ifb));

  pix_t hist[$];
  logic err_exp = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic out_t mk(logic hs, logic vs, logic act, logic ls, logic fs,
                              logic [2:0] r, logic [2:0] g, logic [2:0] b);
    out_t o;
    o.hs = hs; o.vs = vs; o.act = act; o.ls = ls; o.fs = fs;
    o.r = r; o.g = g; o.b = b;
    return o;
  endfunction

  function automatic out_t idle_out(logic hp);
    return mk(~hp, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
  endfunction

  // What a single pixel should look like on the outputs (VSYNC_POL is 0 on both).
  function automatic out_t ref_px(pix_t p, logic hp);
    out_t o;
    bit   inr;
    bit   vis;
    inr   = (p.col < TC) && (p.row < TR);
    vis   = (p.col < AC) && (p.row < AR);
    o     = idle_out(hp);
    if (inr && p.col >= HS0 && p.col <= HS1) o.hs = hp;
    if (inr && p.row >= VS0 && p.row <= VS1) o.vs = 1'b0;
    o.act = vis;
    o.ls  = inr && (p.col == 0);
    o.fs  = inr && (p.col == 0) && (p.row == 0);
    if (vis) begin
      o.r = p.r; o.g = p.g; o.b = p.b;
    end
    return o;
  endfunction

  function automatic out_t exp_out(int d, logic hp);
    if (hist.size() < d) return idle_out(hp);
    return ref_px(hist[hist.size()-d], hp);
  endfunction

  function automatic out_t got_a();
    return mk(ifa.o_HSync, ifa.o_VSync, ifa.o_Active, ifa.o_Line_Start, ifa.o_Frame_Start,
              ifa.o_Red_Video, ifa.o_Grn_Video, ifa.o_Blu_Video);
  endfunction

  function automatic out_t got_b();
    return mk(ifb.o_HSync, ifb.o_VSync, ifb.o_Active, ifb.o_Line_Start, ifb.o_Frame_Start,
              ifb.o_Red_Video, ifb.o_Grn_Video, ifb.o_Blu_Video);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " outA"}, {18'd0, got_a()}, {18'd0, exp_out(DA, 1'b0)});
    chk({tag, " outB"}, {18'd0, got_b()}, {18'd0, exp_out(DB, 1'b1)});
    chk({tag, " errA"}, {31'd0, ifa.o_Range_Err}, {31'd0, err_exp});
    chk({tag, " errB"}, {31'd0, ifb.o_Range_Err}, {31'd0, err_exp});
  endtask

  task automatic drive(input logic en, input int col, input int row,
                       input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
    ifa.i_Pix_En = en; ifa.i_Col_Count = 10'(col); ifa.i_Row_Count = 10'(row);
    ifa.i_Red_Video = r; ifa.i_Grn_Video = g; ifa.i_Blu_Video = b;
    ifb.i_Pix_En = en; ifb.i_Col_Count = 10'(col); ifb.i_Row_Count = 10'(row);
    ifb.i_Red_Video = r; ifb.i_Grn_Video = g; ifb.i_Blu_Video = b;
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic step(input logic en, input int col, input int row,
                      input logic [2:0] r, input logic [2:0] g, input logic [2:0] b,
                      input string tag);
    pix_t p;
    drive(en, col, row, r, g, b);
    @(posedge clk);
    if (en) begin
      p.col = col; p.row = row; p.r = r; p.g = g; p.b = b;
      hist.push_back(p);
      if (hist.size() > 16) void'(hist.pop_front());
      if (col >= TC || row >= TR) err_exp = 1'b1;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    hist.delete();
    err_exp = 1'b0;
    check_all({tag, " async"});
    repeat (2) @(negedge clk);
    check_all({tag, " held"});
    rst_n = 1'b1;
  endtask

  vec_t tbl[16];
  int   hsa, hsb, first_a, first_b, act_line, vs_a, act_rows, fs_a, fs_b;

  initial begin
    tbl[0]  = '{639, 0,   3'd7, 3'd7, 3'd7, mk(1,1,1,0,0,3'd7,3'd7,3'd7)};
    tbl[1]  = '{640, 0,   3'd7, 3'd7, 3'd7, mk(1,1,0,0,0,3'd0,3'd0,3'd0)};
    tbl[2]  = '{657, 10,  3'd5, 3'd3, 3'd1, mk(1,1,0,0,0,3'd0,3'd0,3'd0)};
    tbl[3]  = '{658, 10,  3'd5, 3'd3, 3'd1, mk(0,1,0,0,0,3'd0,3'd0,3'd0)};
    tbl[4]  = '{749, 490, 3'd2, 3'd2, 3'd2, mk(0,0,0,0,0,3'd0,3'd0,3'd0)};
    tbl[5]  = '{750, 491, 3'd2, 3'd2, 3'd2, mk(1,0,0,0,0,3'd0,3'd0,3'd0)};
    tbl[6]  = '{0,   0,   3'd1, 3'd2, 3'd3, mk(1,1,1,1,1,3'd1,3'd2,3'd3)};
    tbl[7]  = '{0,   5,   3'd4, 3'd5, 3'd6, mk(1,1,1,1,0,3'd4,3'd5,3'd6)};
    tbl[8]  = '{0,   480, 3'd7, 3'd7, 3'd7, mk(1,1,0,1,0,3'd0,3'd0,3'd0)};
    tbl[9]  = '{799, 524, 3'd3, 3'd3, 3'd3, mk(1,1,0,0,0,3'd0,3'd0,3'd0)};
    tbl[10] = '{10,  479, 3'd6, 3'd1, 3'd6, mk(1,1,1,0,0,3'd6,3'd1,3'd6)};
    tbl[11] = '{10,  492, 3'd6, 3'd1, 3'd6, mk(1,1,0,0,0,3'd0,3'd0,3'd0)};
    tbl[12] = '{0,   489, 3'd1, 3'd1, 3'd1, mk(1,1,0,1,0,3'd0,3'd0,3'd0)};
    tbl[13] = '{100, 490, 3'd0, 3'd0, 3'd0, mk(1,0,0,0,0,3'd0,3'd0,3'd0)};
    tbl[14] = '{657, 491, 3'd7, 3'd7, 3'd7, mk(1,0,0,0,0,3'd0,3'd0,3'd0)};
    tbl[15] = '{750, 0,   3'd1, 3'd1, 3'd1, mk(1,1,0,0,0,3'd0,3'd0,3'd0)};

    drive(1'b0, 0, 0, 3'd0, 3'd0, 3'd0);
    @(negedge clk);
    do_reset("reset");

    // Table vectors on the default instance: vector k emerges DA-1 edges after its capture.
    for (int k = 0; k < 16 + DA - 1; k++) begin
      if (k < 16) step(1'b1, tbl[k].col, tbl[k].row, tbl[k].r, tbl[k].g, tbl[k].b, "table");
      else        step(1'b1, 700, 520, 3'd0, 3'd0, 3'd0, "table");
      if (k >= DA - 1) chk($sformatf("table[%0d]", k - DA + 1), {18'd0, got_a()}, {18'd0, tbl[k-DA+1].exp});
    end

    // Two full lines; measure the second one.
    hsa = 0; hsb = 0; first_a = -1; first_b = -1; act_line = 0;
    for (int row = 0; row < 2; row++) begin
      for (int col = 0; col < TC; col++) begin
        step(1'b1, col, row, 3'($urandom), 3'($urandom), 3'($urandom), "line");
        if (row == 1) begin
          if (ifa.o_HSync == 1'b0) begin hsa++; if (first_a < 0) first_a = col; end
          if (ifb.o_HSync == 1'b1) begin hsb++; if (first_b < 0) first_b = col; end
          if (ifa.o_Active) act_line++;
        end
      end
    end
    chk("hsync_len_A", 32'(hsa), 32'd92);
    chk("hsync_len_B", 32'(hsb), 32'd92);
    chk("hsync_lag_A", 32'(first_a), 32'(HS0 + DA - 1));
    chk("hsync_lag_B", 32'(first_b), 32'(HS0 + DB - 1));
    chk("line_active", 32'(act_line), 32'd640);

    // Column 0 down every row: vertical sync and visible-row count.
    vs_a = 0; act_rows = 0;
    for (int row = 0; row < TR; row++) begin
      step(1'b1, 0, row, 3'd5, 3'd2, 3'd7, "rows");
      if (ifa.o_VSync == 1'b0) vs_a++;
      if (ifa.o_Active) act_rows++;
    end
    chk("vsync_rows", 32'(vs_a), 32'd2);
    chk("active_rows", 32'(act_rows), 32'd480);
    chk("frame_active", 32'(act_line * act_rows), 32'd307200);

    // Stall across the frame start.
    fs_a = 0; fs_b = 0;
    step(1'b1, 799, 524, 3'd0, 3'd0, 3'd0, "stall");
    step(1'b1, 0, 0, 3'd7, 3'd0, 3'd7, "stall");
    step(1'b1, 1, 0, 3'd1, 3'd1, 3'd1, "stall");
    if (ifa.o_Frame_Start) fs_a++;
    if (ifb.o_Frame_Start) fs_b++;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 2, 0, 3'd2, 3'd2, 3'd2, "stall");
      chk("frame_start_held", {31'd0, ifa.o_Frame_Start}, 32'd1);
    end
    for (int c = 2; c < 8; c++) begin
      step(1'b1, c, 0, 3'd3, 3'd3, 3'd3, "stall");
      if (ifa.o_Frame_Start) fs_a++;
      if (ifb.o_Frame_Start) fs_b++;
    end
    chk("frame_start_count_A", 32'(fs_a), 32'd1);
    chk("frame_start_count_B", 32'(fs_b), 32'd1);

    // Out-of-range column: sticky error, blanked pixel.
    step(1'b1, 900, 0, 3'd7, 3'd7, 3'd7, "range");
    chk("range_err_next", {31'd0, ifa.o_Range_Err}, 32'd1);
    for (int i = 0; i < DB + 2; i++) begin
      step(1'b1, 10 + i, 3, 3'd7, 3'd7, 3'd7, "range");
      if (i == DA - 2 || (DA == 1 && i == 0)) chk("range_px_blank", {18'd0, got_a()}, {18'd0, idle_out(1'b0)});
    end
    step(1'b0, 10, 3, 3'd0, 3'd0, 3'd0, "range");
    chk("range_err_sticky", {31'd0, ifb.o_Range_Err}, 32'd1);
    do_reset("range_clear");

    // Mid-frame asynchronous reset at (300,200).
    for (int c = 296; c < 301; c++) step(1'b1, c, 200, 3'd6, 3'd5, 3'd4, "midrst");
    chk("pre_rst_active", {31'd0, ifa.o_Active}, 32'd1);
    do_reset("midrst");
    step(1'b1, 300, 200, 3'd5, 3'd5, 3'd5, "post_rst");
    chk("post_rst_idle", {31'd0, ifa.o_Active}, 32'd0);
    step(1'b1, 301, 200, 3'd2, 3'd2, 3'd2, "post_rst");
    chk("post_rst_first", {18'd0, got_a()}, {18'd0, mk(1,1,1,0,0,3'd5,3'd5,3'd5)});

    // Randomised traffic, occasionally out of range and stalled.
    for (int i = 0; i < 3000; i++) begin
      int col, row;
      col = ($urandom_range(0, 49) == 0) ? int'($urandom_range(800, 1023)) : int'($urandom_range(0, 799));
      row = ($urandom_range(0, 49) == 0) ? int'($urandom_range(525, 1023)) : int'($urandom_range(0, 524));
      step($urandom_range(0, 3) != 0, col, row, 3'($urandom), 3'($urandom), 3'($urandom), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
